// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: arbitrates whole-line requests from N ports onto one pmem port as BURST_LEN-beat bursts.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (port 0 highest).
module mem_burst_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  localparam int LINE_W   = BEAT_W * BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [LINE_W-1:0]           req_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_address,
  output logic [BEAT_W-1:0]           pmem_wdata,
  input  logic                        pmem_resp,
  input  logic [BEAT_W-1:0]           pmem_rdata
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int KW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int OFF = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] A_MASK = ~ADDR_W'((64'd1 << OFF) - 64'd1);
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [PW-1:0] grant, win;
  logic [LINE_W-1:0] buf_line, sel_wdata, rd_shift;
  logic [ADDR_W-1:0] sel_addr;
  logic [NUM_PORTS-1:0] pending, grant_oh;
  logic found, sel_wr, last;
`ifdef MEM_ARB_RR_EN
  logic [PW-1:0] rr_ptr;
`endif
  assign pending = req_read | req_write;
  assign last = k == KW'(BURST_LEN - 1);
  // The line buffer is a shift register: reads shift beats in at the top, writes shift beats out at the bottom.
  assign rd_shift = LINE_W'({pmem_rdata, buf_line} >> BEAT_W);
  assign pmem_wdata = pmem_write ? buf_line[BEAT_W-1:0] : '0;
  always_comb begin
    int p;
    p = 0;
    found = 1'b0;
    win = '0;
    sel_wr = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
`ifdef MEM_ARB_RR_EN
      p = (int'(rr_ptr) + j) % NUM_PORTS;
`else
      p = j;
`endif
      if (!found && pending[p]) begin
        found = 1'b1;
        win = PW'(p);
        sel_wr = req_write[p];
        sel_addr = req_address[p*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[p*LINE_W +: LINE_W];
      end
    end
  end
  always_comb begin
    grant_oh = '0;
    grant_oh[grant] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k <= '0;
      grant <= '0;
      buf_line <= '0;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
      pmem_address <= '0;
      req_resp <= '0;
      req_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          grant <= win;
          pmem_address <= sel_addr & A_MASK;
          buf_line <= sel_wdata;
          pmem_write <= sel_wr;
          pmem_read <= !sel_wr;
          state <= sel_wr ? WR_BURST : RD_BURST;
        end
        RD_BURST, WR_BURST: if (pmem_resp) begin
          buf_line <= state == RD_BURST ? rd_shift : buf_line >> BEAT_W;
          k <= last ? '0 : k + 1'b1;
          if (last) begin
            state <= DONE;
            pmem_read <= 1'b0;
            pmem_write <= 1'b0;
            req_resp <= grant_oh;
            if (state == RD_BURST) req_rdata <= rd_shift;
          end
        end
        DONE: begin
          req_resp <= '0;
          k <= '0;
          state <= IDLE;
`ifdef MEM_ARB_RR_EN
          rr_ptr <= int'(grant) == NUM_PORTS - 1 ? '0 : grant + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: randomized self-checking bench for mem_burst_arbiter (3 ports, 4 x 64-bit beats).
`timescale 1ns/1ps
module tb_mem_burst_arbiter;
  localparam int NP = 3, AW = 32, BW = 64, BL = 4, LW = BW * BL;
  localparam logic [AW-1:0] MASK = 32'hFFFF_FFE0;
  typedef struct { bit rd; bit wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } op_t;
  typedef struct { logic [AW-1:0] addr; bit wr; int cyc; } start_t;
  typedef struct { logic [NP-1:0] oh; logic [LW-1:0] rdata; logic [LW-1:0] wcap; int cyc; } resp_t;

  logic clk = 0, rst = 0;
  logic [NP-1:0] req_read = '0, req_write = '0, req_resp;
  logic [NP*AW-1:0] req_address = '0;
  logic [NP*LW-1:0] req_wdata = '0;
  logic [LW-1:0] req_rdata;
  logic pmem_read, pmem_write, pmem_resp = 0;
  logic [AW-1:0] pmem_address;
  logic [BW-1:0] pmem_wdata, pmem_rdata = '0;

  mem_burst_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .BEAT_W(BW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_resp(req_resp), .req_rdata(req_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, ncyc = 0;
  op_t tab [NP][8];
  int cnt [NP], pos [NP];
  start_t starts [$];
  resp_t resps [$];
  logic [BW-1:0] wseq [$];
  logic [LW-1:0] rline, wcap, fixed_line;
  bit use_fixed = 0, spurious = 0, saw_read = 0, active_prev = 0;
  int stall_pct = 0, stall_at = -1, stall_n = 0, stall_left = 0, beat = 0;
  logic [31:0] salt = 32'h5A5A_0001;

  function automatic logic [LW-1:0] mkline(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int b = 0; b < BL; b++) l[b*BW +: BW] = {a ^ salt, 32'(b) * 32'h9E37_79B9 + salt};
    return l;
  endfunction

  function automatic op_t mkop(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    op_t o;
    o.rd = rd; o.wr = wr; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int w = 0; w < LW / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic drive_reqs();
    for (int p = 0; p < NP; p++) begin
      if (pos[p] < cnt[p]) begin
        req_read[p] = tab[p][pos[p]].rd;
        req_write[p] = tab[p][pos[p]].wr;
        req_address[p*AW +: AW] = tab[p][pos[p]].addr;
        req_wdata[p*LW +: LW] = tab[p][pos[p]].wdata;
      end else begin
        req_read[p] = 1'b0;
        req_write[p] = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin cnt[p] = 0; pos[p] = 0; end
    drive_reqs();
    starts.delete(); resps.delete(); wseq.delete();
    saw_read = 0;
  endtask

  // One clock: observe outputs after the edge, act as pmem and as the requesting caches.
  task automatic cycle();
    bit active, give;
    @(posedge clk);
    #1;
    ncyc++;
    active = pmem_read || pmem_write;
    if (pmem_read) saw_read = 1;
    if (!active) beat = 0;
    if (active && !active_prev) begin
      starts.push_back('{pmem_address, pmem_write, ncyc});
      rline = use_fixed ? fixed_line : mkline(pmem_address);
      wcap = '0;
      stall_left = stall_at == 0 ? stall_n : 0;
    end
    active_prev = active;
    if (pmem_write) wseq.push_back(pmem_wdata);
    give = 0;
    if (active) begin
      if (stall_left > 0) stall_left--;
      else give = $urandom_range(99) >= stall_pct;
    end
    pmem_resp = give || (!active && spurious && $urandom_range(1) == 1);
    pmem_rdata = (give && pmem_read) ? rline[beat*BW +: BW] : {$urandom, $urandom};
    if (give) begin
      if (pmem_write) wcap[beat*BW +: BW] = pmem_wdata;
      beat++;
      if (beat == stall_at) stall_left = stall_n;
    end
    if (req_resp != '0) begin
      resps.push_back('{req_resp, req_rdata, wcap, ncyc});
      for (int p = 0; p < NP; p++) if (req_resp[p] && pos[p] < cnt[p]) pos[p]++;
      drive_reqs();
    end
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int c = 0;
    while (resps.size() < n && c < budget) begin cycle(); c++; end
    ok = resps.size() >= n;
  endtask

  task automatic do_reset();
    rst = 0;
    repeat (2) cycle();
    rst = 1;
    cycle();
  endtask

  task automatic test_reset();
    bit ok;
    int c = 0;
    rst = 0;
    clear_all();
    repeat (2) cycle();
    n_cmp++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, req_resp, req_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wdata=%h resp=%b, need all 0", pmem_read, pmem_write, pmem_address, pmem_wdata, req_resp);
    end
    rst = 1;
    cycle();
    tab[0][0] = mkop(1, 0, 32'h0000_4040, '0); cnt[0] = 1;
    drive_reqs();
    while (!(pmem_read && beat == 3) && c < 20) begin cycle(); c++; end
    rst = 0;
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_midburst_drop: got rd=%b wr=%b, need 0 0", pmem_read, pmem_write);
    end
    n_cmp++;
    if (req_resp !== '0) begin n_fail++; $display("FAIL reset_midburst_resp: got %b, need 000", req_resp); end
    repeat (2) cycle();
    rst = 1;
    run_until(1, 30, ok);
    n_cmp++;
    if (!ok || starts.size() != 2) begin
      n_fail++; $display("FAIL reset_fresh_burst: got %0d resps %0d bursts, need 1 and 2", resps.size(), starts.size());
    end else begin
      n_cmp++;
      if (resps[0].rdata !== mkline(32'h0000_4040) || resps[0].oh !== 3'b001) begin
        n_fail++; $display("FAIL reset_fresh_data: got oh=%b rdata=%h, need 001 %h", resps[0].oh, resps[0].rdata, mkline(32'h0000_4040));
      end
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int t0;
    clear_all(); do_reset(); clear_all();
    use_fixed = 1;
    fixed_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    tab[1][0] = mkop(1, 0, 32'h0000_1234, '0); cnt[1] = 1;
    drive_reqs();
    t0 = ncyc;
    cycle();
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin
      n_fail++; $display("FAIL read_issue: got rd=%b wr=%b at T+1, need 1 0", pmem_read, pmem_write);
    end
    n_cmp++;
    if (pmem_address !== 32'h0000_1220) begin n_fail++; $display("FAIL read_addr: got %h, need 00001220", pmem_address); end
    run_until(1, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL read_timeout: got 0 resps, need 1");
    end else begin
      n_cmp++;
      if (resps[0].cyc != t0 + 5) begin n_fail++; $display("FAIL read_latency: got T+%0d, need T+5", resps[0].cyc - t0); end
      n_cmp++;
      if (resps[0].oh !== 3'b010) begin n_fail++; $display("FAIL read_oh: got %b, need 010", resps[0].oh); end
      n_cmp++;
      if (resps[0].rdata !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
        n_fail++; $display("FAIL read_line: got %h", resps[0].rdata);
      end
    end
    use_fixed = 0;
  endtask

  task automatic test_single_write();
    bit ok, bad;
    logic [BW-1:0] exp [7];
    logic [LW-1:0] line;
    line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    exp = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    clear_all(); do_reset(); clear_all();
    stall_at = 1; stall_n = 3;
    tab[0][0] = mkop(0, 1, 32'h0000_2010, line); cnt[0] = 1;
    drive_reqs();
    run_until(1, 30, ok);
    repeat (6) cycle();
    bad = wseq.size() != 7;
    for (int i = 0; i < 7 && i < wseq.size(); i++) if (wseq[i] !== exp[i]) bad = 1;
    n_cmp++;
    if (bad) begin
      n_fail++; $display("FAIL write_beats: got %0d beats first=%h second=%h, need 7 beats A,B x4,C,D", wseq.size(), wseq.size() > 0 ? wseq[0] : '0, wseq.size() > 1 ? wseq[1] : '0);
    end
    n_cmp++;
    if (resps.size() != 1 || saw_read) begin
      n_fail++; $display("FAIL write_resp_count: got %0d resps read_seen=%b, need 1 and 0", resps.size(), saw_read);
    end
    if (ok) begin
      n_cmp++;
      if (resps[0].oh !== 3'b001 || resps[0].wcap !== line) begin
        n_fail++; $display("FAIL write_line: got oh=%b line=%h, need 001 %h", resps[0].oh, resps[0].wcap, line);
      end
    end
    stall_at = -1; stall_n = 0;
  endtask

  task automatic test_contention();
    bit ok;
    int exp [6];
    int k [NP];
    int p;
    logic [NP-1:0] eoh;
    op_t o;
`ifdef MEM_ARB_RR_EN
    exp = '{0, 1, 0, 1, 0, 1};
`else
    exp = '{0, 0, 0, 1, 1, 1};
`endif
    clear_all(); do_reset(); clear_all();
    for (int i = 0; i < 3; i++) begin
      tab[0][i] = mkop(1, 0, 32'h0000_1000 + 32'(i) * 32'h40, '0);
      tab[1][i] = mkop(0, 1, 32'h0000_8000 + 32'(i) * 32'h40, rand_line());
    end
    cnt[0] = 3; cnt[1] = 3;
    for (int q = 0; q < NP; q++) k[q] = 0;
    drive_reqs();
    run_until(6, 200, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL contention_timeout: got %0d resps, need 6", resps.size()); end
    for (int i = 0; i < 6 && i < resps.size(); i++) begin
      p = exp[i];
      o = tab[p][k[p]];
      k[p]++;
      eoh = '0; eoh[p] = 1'b1;
      n_cmp++;
      if (resps[i].oh !== eoh) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b, need %b", i, resps[i].oh, eoh); end
      n_cmp++;
      if (o.wr ? resps[i].wcap !== o.wdata : resps[i].rdata !== mkline(o.addr & MASK)) begin
        n_fail++; $display("FAIL contention_data[%0d]: got r=%h w=%h", i, resps[i].rdata, resps[i].wcap);
      end
    end
  endtask

  task automatic test_both_high();
    bit ok, moved = 0;
    int c = 0;
    logic [LW-1:0] line;
    line = rand_line();
    clear_all(); do_reset(); clear_all();
    tab[2][0] = mkop(1, 1, 32'h0000_3008, line); cnt[2] = 1;
    drive_reqs();
    while (!pmem_write && !pmem_read && c < 10) begin cycle(); c++; end
    tab[2][0].addr = 32'h0000_7777;
    drive_reqs();
    c = 0;
    while (resps.size() == 0 && c < 30) begin
      cycle();
      if (pmem_write && pmem_address !== 32'h0000_3000) moved = 1;
      c++;
    end
    ok = resps.size() == 1;
    n_cmp++;
    if (saw_read || starts.size() != 1 || !starts[0].wr) begin
      n_fail++; $display("FAIL both_write_wins: got read_seen=%b bursts=%0d, need write only", saw_read, starts.size());
    end
    n_cmp++;
    if (moved || starts.size() == 0 || starts[0].addr !== 32'h0000_3000) begin
      n_fail++; $display("FAIL both_addr_held: got addr changed=%b, need fixed 00003000", moved);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL both_timeout: got %0d resps, need 1", resps.size());
    end else begin
      n_cmp++;
      if (resps[0].oh !== 3'b100 || resps[0].wcap !== line) begin
        n_fail++; $display("FAIL both_line: got oh=%b line=%h, need 100 %h", resps[0].oh, resps[0].wcap, line);
      end
    end
  endtask

  task automatic test_spurious();
    bit ok;
    clear_all(); do_reset(); clear_all();
    spurious = 1;
    repeat (8) cycle();
    n_cmp++;
    if (starts.size() != 0 || resps.size() != 0) begin
      n_fail++; $display("FAIL spurious_idle: got %0d bursts %0d resps, need 0 0", starts.size(), resps.size());
    end
    tab[0][0] = mkop(1, 0, 32'h0000_5004, '0); cnt[0] = 1;
    drive_reqs();
    run_until(1, 40, ok);
    repeat (10) cycle();
    n_cmp++;
    if (!ok || resps.size() != 1 || starts.size() != 1) begin
      n_fail++; $display("FAIL spurious_count: got %0d resps %0d bursts, need 1 1", resps.size(), starts.size());
    end else begin
      n_cmp++;
      if (resps[0].rdata !== mkline(32'h0000_5000)) begin
        n_fail++; $display("FAIL spurious_data: got %h, need %h", resps[0].rdata, mkline(32'h0000_5000));
      end
    end
    spurious = 0;
  endtask

  task automatic test_random();
    bit ok;
    int total = 0, w, p, kind;
    int rem [NP];
    int k [NP];
    int order [$];
    logic [NP-1:0] eoh;
    op_t o;
`ifdef MEM_ARB_RR_EN
    int ptr = 0;
`endif
    clear_all(); do_reset(); clear_all();
    salt = $urandom;
    stall_pct = 30; spurious = 1;
    for (int q = 0; q < NP; q++) begin
      cnt[q] = $urandom_range(4, 2);
      rem[q] = cnt[q];
      k[q] = 0;
      total += cnt[q];
      for (int i = 0; i < cnt[q]; i++) begin
        kind = $urandom_range(2);
        tab[q][i] = mkop(kind != 1, kind != 0, 32'h0001_0000 * 32'(q + 1) + 32'h100 * 32'(i) + 32'($urandom_range(31)), rand_line());
      end
    end
    // Every port with work left is requesting at each arbitration point.
    for (int g = 0; g < total; g++) begin
      w = -1;
      for (int j = 0; j < NP; j++) begin
`ifdef MEM_ARB_RR_EN
        if (w < 0 && rem[(ptr + j) % NP] > 0) w = (ptr + j) % NP;
`else
        if (w < 0 && rem[j] > 0) w = j;
`endif
      end
      order.push_back(w);
      rem[w]--;
`ifdef MEM_ARB_RR_EN
      ptr = (w + 1) % NP;
`endif
    end
    drive_reqs();
    run_until(total, 3000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL random_timeout: got %0d resps, need %0d", resps.size(), total); end
    for (int i = 0; i < total && i < resps.size() && i < starts.size(); i++) begin
      p = order[i];
      o = tab[p][k[p]];
      k[p]++;
      eoh = '0; eoh[p] = 1'b1;
      n_cmp++;
      if (resps[i].oh !== eoh) begin n_fail++; $display("FAIL random_grant[%0d]: got %b, need %b", i, resps[i].oh, eoh); end
      n_cmp++;
      if (starts[i].addr !== (o.addr & MASK) || starts[i].wr != o.wr) begin
        n_fail++; $display("FAIL random_issue[%0d]: got addr=%h wr=%b, need %h %b", i, starts[i].addr, starts[i].wr, o.addr & MASK, o.wr);
      end
      n_cmp++;
      if (o.wr ? resps[i].wcap !== o.wdata : resps[i].rdata !== mkline(o.addr & MASK)) begin
        n_fail++; $display("FAIL random_data[%0d]: got r=%h w=%h", i, resps[i].rdata, resps[i].wcap);
      end
    end
    stall_pct = 0; spurious = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_both_high();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
